lfsr_word_gen: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random generator and successor to the fixed 4-bit LFSR. It has configurable width, tap mask, seed and output word width. It supports runtime seed load and all-zero lock-up detection. Feedback bits are packed into OUT_W-bit words and delivered over a valid/ready handshake to test-pattern and scrambler consumers.

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr_word_gen_core.sv | 51 +++++
 rtl/lfsr_word_gen.sv | 117 +++++++++++
 tb/tb_lfsr_word_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR word generator.
// Tap masks assume a left shift with the feedback bit entering state[0],
// so bit k of a mask selects the bit that entered k+1 steps ago.
package lfsr_pkg;

  // Word assembly FSM: shifting bits in, or holding a finished word
  typedef enum logic {
    FILL  = 1'b0,
    VALID = 1'b1
  } fsm_e;

  // Maximal-length feedback masks for this shift orientation
  localparam logic [3:0]  TAPS_4  = 4'h9;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hD008;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;

  // Default non-zero seed (legacy 4-bit start value)
  localparam logic [3:0]  SEED_DEFAULT = 4'h1;

endpackage

// File: rtl/lfsr_word_gen_core.sv
// Fibonacci LFSR state register: step, seed load, feedback and lock-up logic.
// Optional macro LFSR_LOCKUP_RECOVER_EN: a zero seed or a zero state is
// replaced by SEED and lockup is tied low.
module lfsr_core #(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = 4'b1001,
  parameter logic [WIDTH-1:0] SEED = 4'b0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  output logic             fb,
  output logic             lockup
);

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] load_val;
  logic             zero_state;

  assign fb         = ^(state_reg & TAPS);
  assign zero_state = (state_reg == '0);
  assign state      = state_reg;

`ifdef LFSR_LOCKUP_RECOVER_EN
  // A zero seed would lock the register, so substitute the default seed
  assign load_val = (seed == '0) ? SEED : seed;
  assign lockup   = 1'b0;
`else
  assign load_val = seed;
  assign lockup   = zero_state;
`endif

  // State register: load beats recovery beats stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SEED;
    end else if (load) begin
      state_reg <= load_val;
`ifdef LFSR_LOCKUP_RECOVER_EN
    end else if (zero_state) begin
      state_reg <= SEED;
`endif
    end else if (step) begin
      state_reg <= {state_reg[WIDTH-2:0], fb};
    end
  end

endmodule

// File: rtl/lfsr_word_gen.sv
// LFSR word generator: packs feedback bits into OUT_W-bit words (first bit
// in the MSB) and hands them out over valid/ready.
// Optional macro LFSR_LOCKUP_RECOVER_EN (handled inside lfsr_core).
module lfsr_word_gen
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = 4'b1001,
  parameter logic [WIDTH-1:0] SEED = 4'b0001,
  parameter int              OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [WIDTH-1:0] state,
  output logic             lockup
);

  localparam int               CNT_W    = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  fsm_e             fsm_reg,   fsm_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic [OUT_W-1:0] word_reg,  word_next;
  logic             valid_reg, valid_next;
  logic             step;
  logic             fb;
  logic [OUT_W-1:0] word_shift;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (step),
    .load   (load),
    .seed   (seed),
    .state  (state),
    .fb     (fb),
    .lockup (lockup)
  );

  // Word shifter input: a 1-bit word is just the feedback bit
  generate
    if (OUT_W == 1) begin : g_word_single
      assign word_shift = fb;
    end else begin : g_word_multi
      assign word_shift = {word_reg[OUT_W-2:0], fb};
    end
  endgenerate

  // FSM, bit counter and word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg   <= FILL;
      cnt_reg   <= '0;
      word_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      fsm_reg   <= fsm_next;
      cnt_reg   <= cnt_next;
      word_reg  <= word_next;
      valid_reg <= valid_next;
    end
  end

  // Next-state logic: load restarts the word, FILL steps, VALID holds
  always_comb begin
    fsm_next   = fsm_reg;
    cnt_next   = cnt_reg;
    word_next  = word_reg;
    valid_next = valid_reg;
    step       = 1'b0;
    if (load) begin
      fsm_next   = FILL;
      cnt_next   = '0;
      word_next  = '0;
      valid_next = 1'b0;
    end else begin
      case (fsm_reg)
        FILL: begin
          if (en) begin
            step      = 1'b1;
            word_next = word_shift;
            if (cnt_reg == CNT_LAST) begin
              cnt_next   = '0;
              valid_next = 1'b1;
              fsm_next   = VALID;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        VALID: begin
          if (out_ready) begin
            valid_next = 1'b0;
            fsm_next   = FILL;
          end
        end
        default: begin
          fsm_next = FILL;
        end
      endcase
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = word_reg;

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Directed testbench for lfsr_word_gen (defaults plus 8/16-bit period runs).
`timescale 1ns/1ps
module tb_lfsr_word_gen;
  import lfsr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, load, out_ready;
  logic [3:0]  seed;
  logic        out_valid, lockup;
  logic [3:0]  out_data, state;

  logic        en8, out_ready8, out_valid8, lockup8;
  logic [7:0]  seed8, out_data8, state8;
  logic        en16, out_ready16, out_valid16, lockup16;
  logic [15:0] seed16, out_data16, state16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_word_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed(seed),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .state(state), .lockup(lockup)
  );

  lfsr_word_gen #(.WIDTH(8), .TAPS(TAPS_8), .SEED(8'h01), .OUT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .load(1'b0), .seed(seed8),
    .out_ready(out_ready8), .out_valid(out_valid8), .out_data(out_data8),
    .state(state8), .lockup(lockup8)
  );

  lfsr_word_gen #(.WIDTH(16), .TAPS(TAPS_16), .SEED(16'h0001), .OUT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en16), .load(1'b0), .seed(seed16),
    .out_ready(out_ready16), .out_valid(out_valid16), .out_data(out_data16),
    .state(state16), .lockup(lockup16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    en = 0; load = 0; seed = 0; out_ready = 0;
    en8 = 0; out_ready8 = 0; seed8 = 0;
    en16 = 0; out_ready16 = 0; seed16 = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 0; load = 0; seed = 0; out_ready = 0;
    en8 = 0; out_ready8 = 0; seed8 = 0;
    en16 = 0; out_ready16 = 0; seed16 = 0;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'b0001) begin failures++; $display("FAIL reset_state actual=%b required=0001", state); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", out_valid); end
    checks++;
    if (lockup !== 1'b0) begin failures++; $display("FAIL reset_lockup actual=%b required=0", lockup); end
    checks++;
    if (out_data !== 4'b0000) begin failures++; $display("FAIL reset_data actual=%b required=0000", out_data); end
    tick();
    rst_n = 1'b1;
    $display("reset: state=%b valid=%b lockup=%b", state, out_valid, lockup);
  endtask

  task automatic test_fill();
    apply_reset();
    en = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL fill_early_valid actual=%b required=0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b1110 || state !== 4'b1110) begin
      failures++;
      $display("FAIL fill_word1 actual valid=%b data=%b state=%b required valid=1 data=1110 state=1110", out_valid, out_data, state);
    end
    $display("fill word1: data=%b state=%b", out_data, state);
    tick();
    checks++;
    if (out_valid !== 1'b0 || state !== 4'b1110) begin
      failures++;
      $display("FAIL fill_handshake actual valid=%b state=%b required valid=0 state=1110", out_valid, state);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b1011 || state !== 4'b1011) begin
      failures++;
      $display("FAIL fill_word2 actual valid=%b data=%b state=%b required valid=1 data=1011 state=1011", out_valid, out_data, state);
    end
    $display("fill word2: data=%b state=%b", out_data, state);
    en = 0;
    tick();
  endtask

  task automatic test_backpressure();
    int bad;
    apply_reset();
    en = 1; out_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== 4'b1110 || state !== 4'b1110) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold actual bad_cycles=%0d data=%b state=%b required bad_cycles=0 data=1110 state=1110", bad, out_data, state);
    end
    out_ready = 1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL backpressure_release actual=%b required=0", out_valid); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL backpressure_single actual extra_valid=%0d required=0", bad); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b1011) begin
      failures++;
      $display("FAIL backpressure_next actual valid=%b data=%b required valid=1 data=1011", out_valid, out_data);
    end
    $display("backpressure: next data=%b state=%b", out_data, state);
    en = 0;
    tick();
  endtask

  task automatic test_load_mid_fill();
    int bad;
    apply_reset();
    en = 1; out_ready = 1;
    tick(); tick();
    load = 1; seed = 4'b1000;
    tick();
    load = 0;
    checks++;
    if (state !== 4'b1000 || out_valid !== 1'b0 || out_data !== 4'b0000) begin
      failures++;
      $display("FAIL load_apply actual state=%b valid=%b data=%b required state=1000 valid=0 data=0000", state, out_valid, out_data);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL load_partial_dropped actual early_valid=%0d required=0", bad); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b1111 || state !== 4'b1111) begin
      failures++;
      $display("FAIL load_word actual valid=%b data=%b state=%b required valid=1 data=1111 state=1111", out_valid, out_data, state);
    end
    $display("load mid-fill: data=%b state=%b", out_data, state);
    en = 0; load = 1; seed = 4'b1000;
    tick();
    load = 0;
    checks++;
    if (out_valid !== 1'b0 || state !== 4'b1000) begin
      failures++;
      $display("FAIL load_vs_handshake actual valid=%b state=%b required valid=0 state=1000", out_valid, state);
    end
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    en = 1; out_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL async_setup actual=%b required=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || state !== 4'b0001) begin
      failures++;
      $display("FAIL async_reset actual valid=%b state=%b required valid=0 state=0001", out_valid, state);
    end
    $display("async reset: valid=%b state=%b", out_valid, state);
    en = 0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_lockup();
    apply_reset();
    load = 1; seed = 4'b0000;
    tick();
    load = 0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    checks++;
    if (state !== 4'b0001 || lockup !== 1'b0) begin
      failures++;
      $display("FAIL lockup_recover actual state=%b lockup=%b required state=0001 lockup=0", state, lockup);
    end
    en = 1; out_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b1110) begin
      failures++;
      $display("FAIL lockup_word actual valid=%b data=%b required valid=1 data=1110", out_valid, out_data);
    end
`else
    checks++;
    if (state !== 4'b0000 || lockup !== 1'b1) begin
      failures++;
      $display("FAIL lockup_flag actual state=%b lockup=%b required state=0000 lockup=1", state, lockup);
    end
    en = 1; out_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b0000 || state !== 4'b0000) begin
      failures++;
      $display("FAIL lockup_word actual valid=%b data=%b state=%b required valid=1 data=0000 state=0000", out_valid, out_data, state);
    end
`endif
    $display("lockup: state=%b lockup=%b data=%b", state, lockup, out_data);
    en = 0;
    tick();
  endtask

  // which: 0 = 4-bit default, 1 = 8-bit, 2 = 16-bit
  task automatic test_period(input int which, input int expect_p, input int bound);
    int  steps;
    bit  done;
    bit  step_now;
    apply_reset();
    case (which)
      0: begin en = 1; out_ready = 1; end
      1: begin en8 = 1; out_ready8 = 1; end
      default: begin en16 = 1; out_ready16 = 1; end
    endcase
    steps = 0;
    done  = 0;
    for (int c = 0; c < bound && !done; c++) begin
      case (which)
        0: step_now = !out_valid;
        1: step_now = !out_valid8;
        default: step_now = !out_valid16;
      endcase
      tick();
      if (step_now) begin
        steps++;
        case (which)
          0: if (state == 4'h1) done = 1;
          1: if (state8 == 8'h01) done = 1;
          default: if (state16 == 16'h0001) done = 1;
        endcase
      end
    end
    en = 0; en8 = 0; en16 = 0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL period_timeout_%0d actual steps=%0d required return within budget", which, steps);
    end
    checks++;
    if (steps != expect_p) begin
      failures++;
      $display("FAIL period_%0d actual=%0d required=%0d", which, steps, expect_p);
    end
    $display("period run %0d: steps=%0d", which, steps);
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_load_mid_fill();
    test_async_reset();
    test_lockup();
    test_period(0, 15, 40);
    test_period(1, 255, 600);
    test_period(2, 65535, 72000);
    checks++;
    if (lockup8 !== 1'b0 || lockup16 !== 1'b0) begin
      failures++;
      $display("FAIL wide_lockup actual l8=%b l16=%b required 0 0", lockup8, lockup16);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
